// File: rtl/mux16_pkg.sv
// Shared definitions for the 16-requester round-robin mux arbiter.
package mux16_pkg;

  localparam int NREQ         = 16;
  localparam int SELW         = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [SELW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping mod 16.
module rr_pick16
  import mux16_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set request overwrites the rest.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SELW'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 16:1 bit mux.
// Owner keeps the grant until done, dropping its request, or MAX_HOLD cycles.
module mux16_rr_arbiter
  import mux16_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF  // legal range 2..255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [SELW-1:0] sel,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            timeout
);

  localparam int              HCW       = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [HCW-1:0]  HOLD_SAT  = '1;

  state_t          state, state_nx;
  logic [SELW-1:0] ptr, ptr_nx;
  logic [SELW-1:0] sel_nx;
  logic [NREQ-1:0] gnt_nx;
  logic            busy_nx, timeout_nx;
  logic [HCW-1:0]  hold_cnt, hold_nx;

  logic            pick_any;
  logic [SELW-1:0] pick_idx;
  logic            rel_user, rel_limit, rel_now;

  rr_pick16 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Owner-initiated release wins over the hold limit, so timeout only flags a pure limit hit.
  assign rel_user  = done | ~req[sel];
  assign rel_limit = (hold_cnt == HOLD_LAST);
  assign rel_now   = (state == ST_GRANT) & (rel_user | rel_limit);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: arbitrate in IDLE, leave GRANT on any release condition.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nx = ST_GRANT;
      ST_GRANT: if (rel_now)  state_nx = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and tenure counter.
  always_comb begin
    sel_nx     = sel;
    gnt_nx     = gnt;
    busy_nx    = busy;
    timeout_nx = 1'b0;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          sel_nx  = pick_idx;
          gnt_nx  = onehot(pick_idx);
          busy_nx = 1'b1;
          hold_nx = '0;
        end
      end
      ST_GRANT: begin
        if (rel_now) begin
          gnt_nx     = '0;
          busy_nx    = 1'b0;
          ptr_nx     = sel + 1'b1;  // releasing owner drops to lowest priority
          timeout_nx = rel_limit & ~rel_user;
        end else begin
          hold_nx = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
    endcase
  end

  // Output, pointer and counter registers; sel is left untouched in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      sel      <= sel_nx;
      gnt      <= gnt_nx;
      busy     <= busy_nx;
      timeout  <= timeout_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: vector table, directed corner sequences,
// and randomized traffic against a tenure-counting reference model.
module tb_mux16_rr_arbiter;

  localparam int MH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the mux, how many grant cycles it has had, where the scan starts.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_ten;
  bit m_to;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        to;
  } vec_t;

  vec_t        tbl[17];
  int          starts[$];
  int          tos;
  int          run;
  logic        prev_busy;
  logic [15:0] rr;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  function automatic logic [21:0] outvec();
    return {sel, gnt, busy, timeout};
  endfunction

  function automatic logic [21:0] model_vec();
    logic [15:0] g;
    g = m_busy ? (16'd1 << m_sel) : 16'd0;
    return {4'(m_sel), g, m_busy, m_to};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_ten = 0; m_to = 0;
  endfunction

  function automatic void model_step(input logic [15:0] r, input logic d);
    bit user, lim, found;
    if (!m_busy) begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < 16; k++) begin
        if (!found && r[(m_ptr + k) % 16]) begin
          found = 1;
          m_sel = (m_ptr + k) % 16;
        end
      end
      if (found) begin
        m_busy = 1;
        m_ten  = 1;
      end
    end else begin
      user = d || !r[m_sel];
      lim  = (m_ten == MH);
      if (user || lim) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 16;
        m_to   = lim && !user;
      end else begin
        m_ten++;
        m_to = 0;
      end
    end
  endfunction

  task automatic do_reset();
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_state", 64'(outvec()), 64'(model_vec()));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tick(input logic [15:0] r, input logic d, input string name);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
    model_step(r, d);
    chk(name, 64'(outvec()), 64'(model_vec()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    req   = '0;
    done  = 1'b0;
    #1;

    // Vectors: inputs for one cycle -> outputs after the following edge.
    tbl[0]  = '{16'h0001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[1]  = '{16'h0001, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{16'h8001, 1'b0, 4'd15, 16'h8000, 1'b1, 1'b0};
    tbl[3]  = '{16'h8001, 1'b1, 4'd15, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{16'h8001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[5]  = '{16'h8001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[6]  = '{16'h8001, 1'b0, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[7]  = '{16'h8000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{16'h8000, 1'b1, 4'd15, 16'h8000, 1'b1, 1'b0};
    tbl[9]  = '{16'h0000, 1'b0, 4'd15, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{16'h0000, 1'b1, 4'd15, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{16'h0004, 1'b1, 4'd2,  16'h0004, 1'b1, 1'b0};
    tbl[12] = '{16'h0000, 1'b1, 4'd2,  16'h0000, 1'b0, 1'b0};
    tbl[13] = '{16'h000C, 1'b0, 4'd3,  16'h0008, 1'b1, 1'b0};
    tbl[14] = '{16'h000C, 1'b1, 4'd3,  16'h0000, 1'b0, 1'b0};
    tbl[15] = '{16'h000C, 1'b0, 4'd2,  16'h0004, 1'b1, 1'b0};
    tbl[16] = '{16'h000C, 1'b1, 4'd2,  16'h0000, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 64'(outvec()),
          64'({tbl[i].sel, tbl[i].gnt, tbl[i].busy, tbl[i].to}));
    end

    // All requesting, nobody finishes: every tenure hits the hold limit.
    do_reset();
    starts.delete();
    tos       = 0;
    run       = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 17 * (MH + 1); c++) begin
      tick(16'hFFFF, 1'b0, "hold_limit");
      if (busy && !prev_busy) starts.push_back(int'(sel));
      if (busy) run++;
      else if (prev_busy) begin
        chk("tenure_len", 64'(run), 64'(MH));
        run = 0;
      end
      if (timeout) tos++;
      prev_busy = busy;
    end
    chk("timeout_count", 64'(tos), 64'(17));
    chk("grant_count", 64'(starts.size()), 64'(17));
    for (int i = 0; i < starts.size() && i < 17; i++)
      chk("sel_order", 64'(starts[i]), 64'(i % 16));

    // done arrives in the same cycle the hold limit is reached.
    do_reset();
    tick(16'h0010, 1'b0, "limit_done_grant");
    for (int c = 0; c < MH - 1; c++) tick(16'h0010, 1'b0, "limit_done_hold");
    tick(16'h0010, 1'b1, "limit_done_release");
    chk("limit_done_no_timeout", 64'({busy, timeout}), 64'(2'b00));

    // Asynchronous reset in the middle of a grant to requester 9.
    do_reset();
    tick(16'h0020, 1'b0, "pre_grant5");
    tick(16'h0020, 1'b1, "pre_release5");
    tick(16'h0200, 1'b0, "grant9");
    tick(16'h0200, 1'b0, "hold9");
    req  = 16'h0000;
    done = 1'b1;
    #1;
    chk("no_comb_path", 64'(outvec()), 64'(model_vec()));
    rst_n = 1'b0;
    #1;
    chk("async_clear", 64'(outvec()), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    chk("held_in_reset", 64'(outvec()), 64'(0));
    rst_n = 1'b1;
    tick(16'h0201, 1'b0, "post_reset_grant");
    chk("ptr_cleared", 64'(sel), 64'(0));
    tick(16'h0201, 1'b1, "post_reset_release");
    tick(16'h0200, 1'b0, "regrant9");
    chk("regrant9_sel", 64'({sel, gnt}), 64'({4'd9, 16'h0200}));

    // Randomized traffic with mostly sticky requests.
    do_reset();
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      rr = rr ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      tick(rr, ($urandom_range(0, 5) == 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
